seg_display_ctrl: RTL

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_pkg.sv | 52 +++++
 rtl/seg_scan_timer.sv | 50 +++++
 rtl/seg_display_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// FSM state encoding, blank/space constants and the ASCII-to-glyph decoder.
package seg_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StClear = 2'd2
  } seg_state_e;

  // All segments off (segments are active-low).
  localparam logic [6:0] BlankGlyph = 7'h7F;
  // ASCII space, written into every slot by INIT and CLEAR.
  localparam logic [7:0] SpaceCode  = 8'h20;

  // Maps '0'-'9', 'A'-'F', 'a'-'f' to active-low {g..a} hex glyphs; anything else is blank.
  function automatic logic [6:0] ascii_to_glyph(input logic [7:0] code);
    logic [3:0] hex;
    logic       ok;
    logic [6:0] glyph;
    ok  = 1'b1;
    hex = code[3:0];
    if (code >= 8'h30 && code <= 8'h39) begin
      hex = code[3:0];
    end else if ((code >= 8'h41 && code <= 8'h46) || (code >= 8'h61 && code <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
      hex = code[3:0] + 4'd9;
    end else begin
      ok = 1'b0;
    end
    case (hex)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return ok ? glyph : BlankGlyph;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timer: counts clk cycles within a digit slot and advances the
// digit index on every slot wrap. Also exposes next-cycle values so the
// registered digit enables can line up exactly with the slot counter.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          slot_start,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          next_slot_start,
  output logic [$clog2(NUM_DIGITS)-1:0] next_digit_idx
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Next count/index: wrap the count at SCAN_DIV-1 and step the index modulo NUM_DIGITS.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign slot_start      = (cnt_q == '0);
  assign digit_idx       = idx_q;
  assign next_slot_start = (cnt_d == '0);
  assign next_digit_idx  = idx_d;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller. Characters shift in at slot 0
// (rightmost digit); INIT and CLEAR blank the buffer one slot per cycle.
// Optional feature: define SEG_BLINK_EN to add the blink input and a
// BLINK_DIV half-period phase counter that blanks the whole display.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
`ifdef SEG_BLINK_EN
  ,
  input  logic                  blink
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  seg_state_e      state_q, state_d;
  logic [IdxW-1:0] fill_q, fill_d;
  logic [7:0]      char_buf_q [NUM_DIGITS];
  logic [7:0]      char_buf_d [NUM_DIGITS];

  logic            slot_start;
  logic [IdxW-1:0] digit_idx;
  logic            next_slot_start;
  logic [IdxW-1:0] next_digit_idx;

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .slot_start      (slot_start),
    .digit_idx       (digit_idx),
    .next_slot_start (next_slot_start),
    .next_digit_idx  (next_digit_idx)
  );

`ifdef SEG_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  // Blink phase toggles every BLINK_DIV cycles.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Blink counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInit;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // FSM next state: INIT/CLEAR walk the fill index once, RUN waits for clear.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    unique case (state_q)
      StInit, StClear: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == IdxW'(NUM_DIGITS - 1)) begin
          state_d = StRun;
          fill_d  = '0;
        end
      end
      StRun: begin
        if (clear) begin
          state_d = StClear;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = StInit;
        fill_d  = '0;
      end
    endcase
  end

  // FSM outputs: accept characters only in RUN and never alongside clear.
  always_comb begin
    char_ready = (state_q == StRun) && !clear;
  end

  // Buffer next state: blank one slot per cycle outside RUN, shift left on accept.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      char_buf_d[k] = char_buf_q[k];
    end
    if (state_q != StRun) begin
      char_buf_d[fill_q] = SpaceCode;
    end else if (char_valid && char_ready) begin
      char_buf_d[0] = char_data;
      for (int k = 1; k < NUM_DIGITS; k++) begin
        char_buf_d[k] = char_buf_q[k-1];
      end
    end
  end

  // Character buffer storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        char_buf_q[k] <= SpaceCode;
      end
    end else begin
      char_buf_q <= char_buf_d;
    end
  end

  // Display drive: enables follow next-cycle scan state so count 0 is always dark.
  always_comb begin
    seg_d = ascii_to_glyph(char_buf_q[digit_idx]);
    an_d  = '1;
    if (!next_slot_start) begin
      an_d[next_digit_idx] = 1'b0;
    end
`ifdef SEG_BLINK_EN
    if (blink && blink_phase_d) begin
      an_d = '1;
    end
`endif
  end

  // Registered segment and digit-enable outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= BlankGlyph;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
